// File: rtl/floo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : floo_pkg
//  Description : Shared types for the mask extract / deposit datapath.
//                mask_mode_e selects gather (extract) or scatter (deposit).
//  Revision    : 1.0 - initial release
// ============================================================================
package floo_pkg;

    // Bit-manipulation mode of the runtime-mask unit.
    //   MaskExtract : gather masked source bits into the low result bits
    //   MaskDeposit : scatter low source bits onto the masked result positions
    typedef enum logic {
        MaskExtract = 1'b0,
        MaskDeposit = 1'b1
    } mask_mode_e;

endpackage
`default_nettype wire

// File: rtl/floo_mask_chunk_step.sv
`default_nettype none
// ============================================================================
//  Module      : floo_mask_chunk_step
//  Description : Combinational single-chunk step of the sequential mask
//                extract / deposit unit. Walks ChunkWidth mask bits in
//                ascending order and folds them into the running accumulator.
//  Ports       :
//    mode_i       : extract or deposit
//    mask_chunk_i : mask bits of the current chunk
//    data_chunk_i : source bits aligned with the current chunk (extract)
//    base_i       : bit offset of the current chunk inside the word
//    ptr_i        : running compacted-bit pointer entering this chunk
//    data_i       : full source word (deposit reads it at ptr)
//    acc_i        : accumulator entering this chunk
//    acc_o        : accumulator leaving this chunk
//    ptr_o        : ptr_i + popcount(mask_chunk_i)
//  Revision    : 1.0 - initial release
// ============================================================================
module floo_mask_chunk_step
    import floo_pkg::*;
#(
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned ChunkWidth = 16,
    parameter int unsigned CntWidth   = 7
) (
    input  mask_mode_e             mode_i,
    input  logic [ChunkWidth-1:0]  mask_chunk_i,
    input  logic [ChunkWidth-1:0]  data_chunk_i,
    input  logic [CntWidth-1:0]    base_i,
    input  logic [CntWidth-1:0]    ptr_i,
    input  logic [DataWidth-1:0]   data_i,
    input  logic [DataWidth-1:0]   acc_i,
    output logic [DataWidth-1:0]   acc_o,
    output logic [CntWidth-1:0]    ptr_o
);

    logic [DataWidth-1:0] w_acc;
    logic [CntWidth-1:0]  w_ptr;

    // Every result position is written at most once per job and the
    // accumulator starts at zero, so OR-ing single bits in is sufficient.
    // Shifts are used instead of variable indexing because the pointer can
    // legally reach DataWidth (all-ones mask) after the last bit.
    always_comb begin
        w_acc = acc_i;
        w_ptr = ptr_i;
        for (int j = 0; j < ChunkWidth; j++) begin
            if (mask_chunk_i[j]) begin
                if (mode_i == MaskExtract) begin
                    w_acc = w_acc | (DataWidth'(data_chunk_i[j]) << w_ptr);
                end else begin
                    w_acc = w_acc | (DataWidth'(1'(data_i >> w_ptr))
                                     << (base_i + CntWidth'(j)));
                end
                w_ptr = w_ptr + CntWidth'(1);
            end
        end
    end

    assign acc_o = w_acc;
    assign ptr_o = w_ptr;

endmodule
`default_nettype wire

// File: rtl/floo_mask_extract_seq.sv
`default_nettype none
// ============================================================================
//  Module      : floo_mask_extract_seq
//  Description : Sequential runtime-mask bit extract (gather) / deposit
//                (scatter) with valid/ready on both sides. ChunkWidth mask
//                bits are handled per cycle by one reused chunk-step unit.
//                Chunk 0 is processed in the accept cycle straight from the
//                inputs; the remaining chunks follow from the registered copy,
//                so the result is valid NumChunks cycles after the accept
//                cycle.
//  Ports       :
//    clk_i   : clock
//    rst_i   : synchronous active-high reset
//    valid_i / ready_o : request handshake (data_i, mask_i, mode_i)
//    valid_o / ready_i : result handshake (data_o, count_o)
//    count_o : popcount(mask)
//  Config      : FLOO_MASK_EXTRACT_SEQ_BACK2BACK_EN - when defined a new job
//                may be accepted in the cycle the previous result is taken,
//                giving one job every NumChunks cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module floo_mask_extract_seq
    import floo_pkg::*;
#(
    parameter  int unsigned DataWidth  = 64,
    parameter  int unsigned ChunkWidth = 16,
    localparam int unsigned CntWidth   = $clog2(DataWidth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    input  logic [DataWidth-1:0] mask_i,
    input  logic                 mode_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic [CntWidth-1:0]  count_o
);

    localparam int unsigned NumChunks = DataWidth / ChunkWidth;
    localparam int unsigned IdxWidth  = (NumChunks > 1) ? $clog2(NumChunks) : 1;

    if ((DataWidth < 1) || (ChunkWidth < 1) || ((DataWidth % ChunkWidth) != 0))
    begin : g_bad_cfg
        $error("floo_mask_extract_seq: ChunkWidth must divide DataWidth");
    end

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Busy = 2'd1,
        Done = 2'd2
    } state_e;

    state_e                r_state;
    logic [IdxWidth-1:0]   r_chunk_idx;
    logic [DataWidth-1:0]  r_data;
    logic [DataWidth-1:0]  r_mask;
    mask_mode_e            r_mode;
    logic [DataWidth-1:0]  r_acc;
    logic [CntWidth-1:0]   r_ptr;
    logic                  r_valid;
    logic [DataWidth-1:0]  r_data_o;
    logic [CntWidth-1:0]   r_count;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_last;
    mask_mode_e            w_mode;
    logic [DataWidth-1:0]  w_data_src;
    logic [DataWidth-1:0]  w_mask_src;
    logic [DataWidth-1:0]  w_acc_src;
    logic [CntWidth-1:0]   w_ptr_src;
    logic [IdxWidth-1:0]   w_chunk_idx;
    logic [CntWidth-1:0]   w_base;
    logic [ChunkWidth-1:0] w_mask_chunk;
    logic [ChunkWidth-1:0] w_data_chunk;
    logic [DataWidth-1:0]  w_acc_next;
    logic [CntWidth-1:0]   w_ptr_next;

`ifdef FLOO_MASK_EXTRACT_SEQ_BACK2BACK_EN
    assign w_ready = (r_state == Idle) || ((r_state == Done) && ready_i);
`else
    assign w_ready = (r_state == Idle);
`endif

    assign w_accept = valid_i && w_ready;

    // In the accept cycle the step unit works on the live inputs (chunk 0,
    // fresh pointer and accumulator); afterwards on the registered job.
    assign w_mode      = w_accept ? mask_mode_e'(mode_i) : r_mode;
    assign w_data_src  = w_accept ? data_i : r_data;
    assign w_mask_src  = w_accept ? mask_i : r_mask;
    assign w_acc_src   = w_accept ? '0 : r_acc;
    assign w_ptr_src   = w_accept ? '0 : r_ptr;
    assign w_chunk_idx = w_accept ? '0 : r_chunk_idx;

    assign w_base       = CntWidth'(w_chunk_idx) * CntWidth'(ChunkWidth);
    assign w_mask_chunk = ChunkWidth'(w_mask_src >> w_base);
    assign w_data_chunk = ChunkWidth'(w_data_src >> w_base);
    assign w_last       = (w_chunk_idx == IdxWidth'(NumChunks - 1));

    floo_mask_chunk_step #(
        .DataWidth  (DataWidth),
        .ChunkWidth (ChunkWidth),
        .CntWidth   (CntWidth)
    ) u_step (
        .mode_i       (w_mode),
        .mask_chunk_i (w_mask_chunk),
        .data_chunk_i (w_data_chunk),
        .base_i       (w_base),
        .ptr_i        (w_ptr_src),
        .data_i       (w_data_src),
        .acc_i        (w_acc_src),
        .acc_o        (w_acc_next),
        .ptr_o        (w_ptr_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= Idle;
            r_chunk_idx <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_mode      <= MaskExtract;
            r_acc       <= '0;
            r_ptr       <= '0;
            r_valid     <= 1'b0;
            r_data_o    <= '0;
            r_count     <= '0;
        end else if (w_accept) begin
            // Covers both Idle and the back-to-back handoff out of Done.
            r_data      <= data_i;
            r_mask      <= mask_i;
            r_mode      <= mask_mode_e'(mode_i);
            r_acc       <= w_acc_next;
            r_ptr       <= w_ptr_next;
            r_chunk_idx <= w_chunk_idx + IdxWidth'(1);
            if (w_last) begin
                r_state  <= Done;
                r_valid  <= 1'b1;
                r_data_o <= w_acc_next;
                r_count  <= w_ptr_next;
            end else begin
                r_state  <= Busy;
                r_valid  <= 1'b0;
            end
        end else begin
            case (r_state)
                Busy: begin
                    r_acc       <= w_acc_next;
                    r_ptr       <= w_ptr_next;
                    r_chunk_idx <= r_chunk_idx + IdxWidth'(1);
                    if (w_last) begin
                        r_state  <= Done;
                        r_valid  <= 1'b1;
                        r_data_o <= w_acc_next;
                        r_count  <= w_ptr_next;
                    end
                end
                Done: begin
                    if (ready_i) begin
                        r_state <= Idle;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready_o = w_ready;
    assign valid_o = r_valid;
    assign data_o  = r_data_o;
    assign count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_floo_mask_extract_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_floo_mask_extract_seq
//  Description : Self-checking bench for floo_mask_extract_seq. Four DUTs:
//                index 0 is DataWidth=16/ChunkWidth=4 (directed scenarios),
//                indices 1..3 are DataWidth=64 with ChunkWidth 1, 8, 64
//                (random jobs with random result backpressure). A PEXT/PDEP
//                reference model predicts every result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_floo_mask_extract_seq;

`ifdef FLOO_MASK_EXTRACT_SEQ_BACK2BACK_EN
    localparam int SPACING = 4;
`else
    localparam int SPACING = 5;
`endif

    logic clk = 1'b0;
    logic rst;

    logic [3:0]       vi, mo, ri, ro, vo, rdy_force, bp_rand;
    logic [3:0][63:0] di, mi, dout;
    logic [3:0][6:0]  cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [3:0]  pend, seen;
    logic [63:0] exp_d [4];
    logic [6:0]  exp_c [4];
    int          acc_cyc [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DW   = (g == 0) ? 16 : 64;
        localparam int CW   = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 64;
        localparam int CNTW = $clog2(DW + 1);
        logic [DW-1:0]   d_o;
        logic [CNTW-1:0] c_o;
        floo_mask_extract_seq #(
            .DataWidth  (DW),
            .ChunkWidth (CW)
        ) u_dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .valid_i (vi[g]),
            .ready_o (ro[g]),
            .data_i  (di[g][DW-1:0]),
            .mask_i  (mi[g][DW-1:0]),
            .mode_i  (mo[g]),
            .valid_o (vo[g]),
            .ready_i (ri[g]),
            .data_o  (d_o),
            .count_o (c_o)
        );
        assign dout[g] = 64'(d_o);
        assign cnt[g]  = 7'(c_o);
    end

    // Result-side ready: forced level or random backpressure per DUT.
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < 4; k++)
            ri[k] = bp_rand[k] ? ($urandom_range(3, 0) != 0) : rdy_force[k];
    end

    function automatic int nc_of(input int k);
        case (k)
            0:       return 4;
            1:       return 64;
            2:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int dw_of(input int k);
        return (k == 0) ? 16 : 64;
    endfunction

    // Software PEXT / PDEP over the low w bits.
    function automatic logic [63:0] ref_result(input logic md, input logic [63:0] d,
                                               input logic [63:0] m, input int w);
        logic [63:0] r;
        int p;
        r = '0;
        p = 0;
        for (int i = 0; i < w; i++) begin
            if (m[i]) begin
                if (!md) r[p] = d[i];
                else     r[i] = d[p];
                p++;
            end
        end
        return r;
    endfunction

    function automatic int popc(input logic [63:0] m, input int w);
        int c;
        c = 0;
        for (int i = 0; i < w; i++) c += int'(m[i]);
        return c;
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d got=%0h want=%0h", name, k, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pend = '0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (vo[k]) begin
                        if (!pend[k]) begin
                            total++;
                            bad++;
                            $display("FAIL spurious_valid dut=%0d got valid_o=1 want 0", k);
                        end else begin
                            if (!seen[k]) begin
                                chk("latency", k, 64'(cyc - acc_cyc[k]), 64'(nc_of(k)));
                                seen[k] = 1'b1;
                            end
                            chk("data_o", k, dout[k], exp_d[k]);
                            chk("count_o", k, 64'(cnt[k]), 64'(exp_c[k]));
                            if (ri[k]) pend[k] = 1'b0;
                        end
                    end else if (pend[k] && ((cyc - acc_cyc[k]) > nc_of(k))) begin
                        total++;
                        bad++;
                        $display("FAIL missing_valid dut=%0d got valid_o=0 want 1", k);
                        pend[k] = 1'b0;
                    end
                    if (vi[k] && ro[k]) begin
                        if (pend[k]) begin
                            total++;
                            bad++;
                            $display("FAIL accept_while_busy dut=%0d got accept want none", k);
                        end
                        pend[k]    = 1'b1;
                        seen[k]    = 1'b0;
                        exp_d[k]   = ref_result(mo[k], di[k], mi[k], dw_of(k));
                        exp_c[k]   = 7'(popc(mi[k], dw_of(k)));
                        acc_cyc[k] = cyc;
                    end
                end
            end
        end
    endtask

    // Called and returns 1 time unit after a rising edge.
    task automatic send(input int k, input logic md, input logic [63:0] d,
                        input logic [63:0] m);
        int t;
        t = 0;
        vi[k] = 1'b1;
        mo[k] = md;
        di[k] = d;
        mi[k] = m;
        @(negedge clk);
        while (!ro[k] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!ro[k]) begin
            total++;
            bad++;
            $display("FAIL accept_timeout dut=%0d got ready_o=0 want 1", k);
        end
        @(posedge clk);
        #1;
        vi[k] = 1'b0;
        di[k] = {$urandom, $urandom};
        mi[k] = {$urandom, $urandom};
        mo[k] = 1'($urandom);
    endtask

    task automatic wait_res(input string name, input int k, input logic [63:0] ed,
                            input int ec, input int en);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vo[k] && n < 3000);
        chk({name, "_valid"}, k, 64'(vo[k]), 64'(1));
        if (en >= 0) chk({name, "_lat"}, k, 64'(n), 64'(en));
        chk({name, "_data"}, k, dout[k], ed);
        chk({name, "_cnt"}, k, 64'(cnt[k]), 64'(ec));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand_mask();
        case ($urandom_range(4, 0))
            0:       return '0;
            1:       return '1;
            2:       return {$urandom, $urandom};
            3:       return {$urandom, $urandom} & {$urandom, $urandom};
            default: return {$urandom, $urandom} | {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int fires[$];
        bit f;
        int t;

        rst       = 1'b1;
        vi        = '0;
        mo        = '0;
        di        = '0;
        mi        = '0;
        rdy_force = '1;
        bp_rand   = '0;
        pend      = '0;
        seen      = '0;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_ready", k, 64'(ro[k]), 64'(1));
            chk("rst_valid", k, 64'(vo[k]), 64'(0));
            chk("rst_data", k, dout[k], 64'(0));
            chk("rst_cnt", k, 64'(cnt[k]), 64'(0));
        end
        @(posedge clk);
        #1;

        // 1. Extract
        send(0, 1'b0, 64'hFFFF, 64'hA5A5);
        wait_res("t1", 0, 64'h00FF, 8, 4);
        // 2. Deposit
        send(0, 1'b1, 64'h00AB, 64'hF0F0);
        wait_res("t2", 0, 64'hA0B0, 8, 4);
        // 3. Empty and full masks
        send(0, 1'b0, 64'h1234, 64'h0000);
        wait_res("t3_zero", 0, 64'h0000, 0, 4);
        send(0, 1'b0, 64'h1234, 64'hFFFF);
        wait_res("t3_full", 0, 64'h1234, 16, 4);

        // 4. Result held under backpressure, extra request refused
        rdy_force[0] = 1'b0;
        send(0, 1'b0, 64'h5A3C, 64'h0FF0);
        wait_res("t4", 0, 64'h00A3, 8, -1);
        vi[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 0, 64'(vo[0]), 64'(1));
            chk("t4_hold_ready", 0, 64'(ro[0]), 64'(0));
            chk("t4_hold_data", 0, dout[0], 64'h00A3);
            chk("t4_hold_cnt", 0, 64'(cnt[0]), 64'(8));
            @(posedge clk);
            #1;
        end
        vi[0]        = 1'b0;
        rdy_force[0] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_release", 0, 64'(vo[0]), 64'(0));
        @(posedge clk);
        #1;

        // 5. Reset in the second busy cycle discards the job
        send(0, 1'b1, 64'hFFFF, 64'hFFFF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_valid", 0, 64'(vo[0]), 64'(0));
        chk("t5_ready", 0, 64'(ro[0]), 64'(1));
        chk("t5_data", 0, dout[0], 64'(0));
        chk("t5_cnt", 0, 64'(cnt[0]), 64'(0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_no_result", 0, 64'(vo[0]), 64'(0));
        end
        @(posedge clk);
        #1;

        // 6. Continuous requests, always-ready result side
        vi[0] = 1'b1;
        di[0] = 64'($urandom_range(65535, 0));
        mi[0] = 64'($urandom_range(65535, 0));
        mo[0] = 1'($urandom);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            f = ro[0];
            if (f) fires.push_back(i);
            @(posedge clk);
            #1;
            if (f) begin
                di[0] = 64'($urandom_range(65535, 0));
                mi[0] = 64'($urandom_range(65535, 0));
                mo[0] = 1'($urandom);
            end
        end
        vi[0] = 1'b0;
        chk("t6_fire_count", 0, 64'(fires.size() >= 7), 64'(1));
        for (int i = 1; i < fires.size(); i++)
            chk("t6_spacing", 0, 64'(fires[i] - fires[i-1]), 64'(SPACING));
        repeat (8) begin
            @(posedge clk);
            #1;
        end

        // Random jobs on the 64-bit instances
        for (int k = 1; k < 4; k++) begin
            bp_rand[k] = 1'b1;
            for (int j = 0; j < 50; j++) begin
                repeat ($urandom_range(2, 0)) begin
                    @(posedge clk);
                    #1;
                end
                send(k, 1'($urandom), {$urandom, $urandom}, rand_mask());
            end
            t = 0;
            while (pend[k] && t < 3000) begin
                @(posedge clk);
                #1;
                t++;
            end
            bp_rand[k] = 1'b0;
        end

        t = 0;
        while ((pend != 4'b0) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (pend != 4'b0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got pending=%b want 0000", pend);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
